// File: rtl/drec_pkg.sv
// Shared definitions for the recorder button front end.
// Holds the 2-bit gesture FSM state encoding and the default timing
// widths that suit a 1 MHz system clock.
package drec_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_RELEASED = 2'd2;
  localparam logic [1:0] ST_LONG     = 2'd3;

  // 2^10 cycles ~ 1 ms debounce, 2^19 ~ 0.5 s release window,
  // 2^21 ~ 2 s long-press threshold.
  localparam int DEF_DEBOUNCE_WIDTH = 10;
  localparam int DEF_WAIT_WIDTH     = 19;
  localparam int DEF_LONG_WIDTH     = 21;
  localparam int DEF_MAX_CLICKS     = 3;
  localparam int DEF_CLICK_WIDTH    = 2;

endpackage

// File: rtl/multi_click_debounce.sv
// debounce: 2-FF synchroniser followed by a stability counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   button     : raw asynchronous input
//   db         : debounced level
//   db_rise    : one-cycle strobe, high in the first cycle db is 1
//   db_fall    : one-cycle strobe, high in the first cycle db is 0
// The debounced level follows the synchronised input only after it has
// differed from db for 2^DEBOUNCE_WIDTH consecutive cycles.
module debounce
  import drec_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEF_DEBOUNCE_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic db,
  output logic db_rise,
  output logic db_fall
);

  logic                      sync_p0;
  logic                      sync_p1;
  logic [DEBOUNCE_WIDTH-1:0] stable_cnt;

  // Synchroniser stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // Stability stage: any cycle where the input agrees with db restarts
  // the count, so a bounce never accumulates towards a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      db         <= 1'b0;
      db_rise    <= 1'b0;
      db_fall    <= 1'b0;
    end else begin
      db_rise <= 1'b0;
      db_fall <= 1'b0;
      if (sync_p1 != db) begin
        if (&stable_cnt) begin
          db         <= sync_p1;
          db_rise    <= sync_p1;
          db_fall    <= ~sync_p1;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + DEBOUNCE_WIDTH'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_click.sv
// multi_click: button gesture decoder (multi-click count and long press).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   button      : raw push-button, active high, asynchronous to clk
//   click_valid : one-cycle pulse when a click gesture completes
//   click_count : clicks in the completed gesture, held until next pulse
//   long_press  : one-cycle pulse when the long-press threshold is hit
//   held        : high while a long press is still held down
module multi_click
  import drec_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEF_DEBOUNCE_WIDTH,
  parameter int WAIT_WIDTH     = DEF_WAIT_WIDTH,
  parameter int LONG_WIDTH     = DEF_LONG_WIDTH,
  parameter int MAX_CLICKS     = DEF_MAX_CLICKS,
  parameter int CLICK_WIDTH    = DEF_CLICK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   button,
  output logic                   click_valid,
  output logic [CLICK_WIDTH-1:0] click_count,
  output logic                   long_press,
  output logic                   held
);

  localparam logic [CLICK_WIDTH-1:0] MAX_CNT = CLICK_WIDTH'(MAX_CLICKS);

  logic                   db;
  logic                   db_rise;
  logic                   db_fall;
  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic [LONG_WIDTH-1:0]  timer;
  logic [CLICK_WIDTH-1:0] cnt;
  logic [CLICK_WIDTH-1:0] cnt_nx;
  logic [CLICK_WIDTH-1:0] count_nx;
  logic                   valid_nx;
  logic                   long_nx;
  logic                   held_nx;
  logic                   win_exp;
  logic                   long_exp;

  debounce #(
    .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
  ) u_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .db     (db),
    .db_rise(db_rise),
    .db_fall(db_fall)
  );

  // One timer serves both the release window (low bits) and the long
  // press threshold (all bits); it restarts on every state change.
  assign win_exp  = &timer[WAIT_WIDTH-1:0];
  assign long_exp = &timer;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    count_nx = click_count;
    valid_nx = 1'b0;
    long_nx  = 1'b0;
    held_nx  = held;
    case (state)
      ST_IDLE: begin
        if (db_rise) begin
          state_nx = ST_PRESSED;
          cnt_nx   = CLICK_WIDTH'(1);
        end
      end
      ST_PRESSED: begin
        // A release in the expiry cycle still counts as a click.
        if (db_fall) begin
          if (cnt == MAX_CNT) begin
            valid_nx = 1'b1;
            count_nx = cnt;
            cnt_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_RELEASED;
          end
        end else if (long_exp && db) begin
          long_nx  = 1'b1;
          held_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_LONG;
        end
      end
      ST_RELEASED: begin
        // A new press in the expiry cycle extends the gesture.
        if (db_rise) begin
          if (cnt != MAX_CNT) cnt_nx = cnt + CLICK_WIDTH'(1);
          state_nx = ST_PRESSED;
        end else if (win_exp) begin
          valid_nx = 1'b1;
          count_nx = cnt;
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end
      end
      ST_LONG: begin
        held_nx = 1'b1;
        if (db_fall) begin
          held_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        held_nx  = 1'b0;
      end
    endcase
  end

  // FSM, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      timer       <= '0;
      click_valid <= 1'b0;
      click_count <= '0;
      long_press  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      click_valid <= valid_nx;
      click_count <= count_nx;
      long_press  <= long_nx;
      held        <= held_nx;
      if (state_nx != state) begin
        timer <= '0;
      end else if (((state == ST_PRESSED) || (state == ST_RELEASED)) && !long_exp) begin
        timer <= timer + LONG_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_click.sv
// Bench for multi_click with short timing parameters. A cycle-level
// behavioural model derives the expected outputs from the gesture rules;
// literal expectations pin the pulse counts and latencies.
module tb_multi_click;

  localparam int DW   = 2;
  localparam int WW   = 4;
  localparam int LW   = 6;
  localparam int MAXC = 3;
  localparam int CW   = 2;

  localparam int DEB_N  = 2 ** DW;
  localparam int WIN_T  = 2 ** WW - 1;
  localparam int LONG_T = 2 ** LW - 1;

  logic          clk;
  logic          rst_n;
  logic          button;
  logic          click_valid;
  logic [CW-1:0] click_count;
  logic          long_press;
  logic          held;

  multi_click #(
    .DEBOUNCE_WIDTH(DW),
    .WAIT_WIDTH    (WW),
    .LONG_WIDTH    (LW),
    .MAX_CLICKS    (MAXC),
    .CLICK_WIDTH   (CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .click_valid(click_valid),
    .click_count(click_count),
    .long_press (long_press),
    .held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   cyc = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;
  int   m_phase = 0;     // 0 idle, 1 button down, 2 waiting for next press, 3 long hold
  int   m_clicks = 0;
  int   m_t_enter = 0;
  int   m_t_rise = 0;
  int   m_t_fall = 0;
  int   m_rises = 0;
  logic e_valid = 1'b0, e_long = 1'b0, e_held = 1'b0;
  int   e_count = 0;
  logic nr, nf, moved;
  int   age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_rise = 0; m_fall = 0; m_run = 0;
      m_phase = 0; m_clicks = 0;
      e_valid = 0; e_long = 0; e_held = 0; e_count = 0;
    end else begin
      age = cyc - m_t_enter;
      moved = 0;
      e_valid = 0;
      e_long = 0;
      case (m_phase)
        0: if (m_rise) begin m_phase = 1; m_clicks = 1; moved = 1; end
        1: if (m_fall) begin
             if (m_clicks == MAXC) begin
               e_valid = 1; e_count = m_clicks; m_phase = 0;
             end else m_phase = 2;
             moved = 1;
           end else if (age >= LONG_T) begin
             e_long = 1; e_held = 1; m_phase = 3; m_clicks = 0; moved = 1;
           end
        2: if (m_rise) begin
             m_clicks = m_clicks + 1; m_phase = 1; moved = 1;
           end else if (age >= WIN_T) begin
             e_valid = 1; e_count = m_clicks; m_phase = 0; moved = 1;
           end
        default: if (m_fall) begin e_held = 0; m_phase = 0; moved = 1; end
      endcase
      nr = 0;
      nf = 0;
      if (m_s2 != m_db) begin
        m_run = m_run + 1;
        if (m_run == DEB_N) begin
          m_db = m_s2; nr = m_s2; nf = !m_s2; m_run = 0;
        end
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = button;
      m_rise = nr;
      m_fall = nf;
      cyc = cyc + 1;
      if (moved) m_t_enter = cyc;
      if (nr) begin m_t_rise = cyc; m_rises = m_rises + 1; end
      if (nf) m_t_fall = cyc;
    end
  end

  // ---------------- compare process ----------------
  int   tot_valid = 0, tot_long = 0, dut_rises = 0;
  int   last_count = -1, valid_lat = -1, long_lat = -1, held_lat = -1;
  logic prev_held = 1'b0;

  always @(negedge clk) begin
    check("click_valid", int'(click_valid), int'(e_valid));
    check("click_count", int'(click_count), e_count);
    check("long_press",  int'(long_press),  int'(e_long));
    check("held",        int'(held),        int'(e_held));
    if (u_dut.db_rise === 1'b1) dut_rises++;
    if (click_valid === 1'b1) begin
      tot_valid++;
      last_count = int'(click_count);
      valid_lat  = cyc - m_t_fall;
    end
    if (long_press === 1'b1) begin
      tot_long++;
      long_lat = cyc - m_t_rise;
    end
    if (prev_held === 1'b1 && held === 1'b0 && rst_n === 1'b1) held_lat = cyc - m_t_fall;
    prev_held = held;
  end

  // ---------------- stimulus ----------------
  task automatic hold_lvl(input logic v, input int n);
    button = v;
    repeat (n) @(negedge clk);
  endtask

  int bv, bl, br;

  initial begin
    rst_n  = 1'b1;
    button = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", int'(click_valid), 0);
    check("rst_count", int'(click_count), 0);
    check("rst_long",  int'(long_press), 0);
    check("rst_held",  int'(held), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single click
    bv = tot_valid; bl = tot_long;
    hold_lvl(1, 10); hold_lvl(0, 40);
    check("t1_pulses", tot_valid - bv, 1);
    check("t1_count", last_count, 1);
    check("t1_latency", valid_lat, 17);
    check("t1_long", tot_long - bl, 0);

    // double click
    bv = tot_valid;
    hold_lvl(1, 8); hold_lvl(0, 8); hold_lvl(1, 8); hold_lvl(0, 40);
    check("t2_pulses", tot_valid - bv, 1);
    check("t2_count", last_count, 2);
    check("t2_latency", valid_lat, 17);

    // max clicks: no window wait, then a fresh gesture
    bv = tot_valid;
    hold_lvl(1, 8); hold_lvl(0, 8); hold_lvl(1, 8); hold_lvl(0, 8);
    hold_lvl(1, 8); hold_lvl(0, 12);
    check("t3_pulses", tot_valid - bv, 1);
    check("t3_count", last_count, 3);
    check("t3_latency", valid_lat, 1);
    hold_lvl(1, 8); hold_lvl(0, 40);
    check("t3_next_pulses", tot_valid - bv, 2);
    check("t3_next_count", last_count, 1);

    // long press
    bv = tot_valid; bl = tot_long;
    hold_lvl(1, 80);
    check("t4_held_high", int'(held), 1);
    hold_lvl(0, 40);
    check("t4_long_pulses", tot_long - bl, 1);
    check("t4_long_latency", long_lat, 65);
    check("t4_held_drop", held_lat, 1);
    check("t4_no_click", tot_valid - bv, 0);

    // bounce then settle
    bv = tot_valid; br = dut_rises;
    for (int i = 0; i < 20; i++) hold_lvl(~button, 1);
    hold_lvl(1, 10); hold_lvl(0, 40);
    check("t5_rises", dut_rises - br, 1);
    check("t5_pulses", tot_valid - bv, 1);
    check("t5_count", last_count, 1);
    // short glitch is ignored
    bv = tot_valid; br = dut_rises; bl = tot_long;
    hold_lvl(1, 3); hold_lvl(0, 30);
    check("t5_glitch_rises", dut_rises - br, 0);
    check("t5_glitch_model_rises", m_rises - br, 0);
    check("t5_glitch_pulses", tot_valid - bv + tot_long - bl, 0);

    // reset mid-gesture
    bv = tot_valid;
    hold_lvl(1, 8); hold_lvl(0, 8); hold_lvl(1, 8); hold_lvl(0, 10);
    check("t6_model_phase", m_phase, 2);
    check("t6_model_clicks", m_clicks, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(click_valid), 0);
    check("t6_rst_count", int'(click_count), 0);
    check("t6_rst_long",  int'(long_press), 0);
    check("t6_rst_held",  int'(held), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold_lvl(0, 40);
    check("t6_no_pulse", tot_valid - bv, 0);
    hold_lvl(1, 10); hold_lvl(0, 40);
    check("t6_after_pulses", tot_valid - bv, 1);
    check("t6_after_count", last_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
